// File: rtl/mem_access_stage.sv
// RV32 MEM pipeline stage: drives a req/ack data-memory bus, aligns store lanes,
// extends load data, stalls upstream while waiting, registers results for MEM_WB.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] storeData_i,
  input  logic [4:0]  rd_i,
  input  logic        RegWrite_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        valid_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] memWrite_out2_o,
  output logic [4:0]  rd_o,
  output logic        RegWrite_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Instruction captured at accept; drives the bus for the whole WAIT phase.
  logic            lat_we_q, lat_we_d;
  logic            lat_load_q, lat_load_d;
  logic [2:0]      lat_f3_q, lat_f3_d;
  logic [31:0]     lat_addr_q, lat_addr_d;
  logic [3:0]      lat_be_q, lat_be_d;
  logic [31:0]     lat_wdata_q, lat_wdata_d;
  logic [4:0]      lat_rd_q, lat_rd_d;
  logic            lat_rw_q, lat_rw_d;

  logic            valid_q, valid_d;
  logic [31:0]     alu_q, alu_d;
  logic [31:0]     mdata_q, mdata_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            misalign_q, misalign_d;
  logic            timeout_q, timeout_d;

  logic [1:0]      in_off;
  logic [3:0]      in_be;
  logic [31:0]     in_wdata;
  logic            in_mem;
  logic            in_mis;

  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    in_off   = ALUResult_i[1:0];
    in_mem   = MemRead_i | MemWrite_i;
    in_wdata = storeData_i << {in_off, 3'b000};
    case (funct3_i[1:0])
      2'b00:   in_be = 4'b0001 << in_off;
      2'b01:   in_be = 4'b0011 << in_off;
      default: in_be = 4'b1111;
    endcase
    in_mis = ((funct3_i[1:0] == 2'b01) && in_off[0]) ||
             (funct3_i[1] && (in_off != 2'b00));
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_we_d     = lat_we_q;
    lat_load_d   = lat_load_q;
    lat_f3_d     = lat_f3_q;
    lat_addr_d   = lat_addr_q;
    lat_be_d     = lat_be_q;
    lat_wdata_d  = lat_wdata_q;
    lat_rd_d     = lat_rd_q;
    lat_rw_d     = lat_rw_q;
    valid_d      = 1'b0;
    alu_d        = '0;
    mdata_d      = '0;
    rd_d         = '0;
    rw_d         = 1'b0;
    misalign_d   = 1'b0;
    timeout_d    = 1'b0;
    stall_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (!in_mem) begin
            valid_d = 1'b1;
            alu_d   = ALUResult_i;
            rd_d    = rd_i;
            rw_d    = RegWrite_i;
          end else if (in_mis) begin
            valid_d    = 1'b1;
            misalign_d = 1'b1;
            alu_d      = ALUResult_i;
            rd_d       = rd_i;
          end else begin
            stall_o      = 1'b1;
            dmem_req_o   = 1'b1;
            dmem_we_o    = MemWrite_i;
            dmem_addr_o  = {ALUResult_i[31:2], 2'b00};
            dmem_be_o    = in_be;
            dmem_wdata_o = in_wdata;
            lat_we_d     = MemWrite_i;
            lat_load_d   = MemRead_i;
            lat_f3_d     = funct3_i;
            lat_addr_d   = ALUResult_i;
            lat_be_d     = in_be;
            lat_wdata_d  = in_wdata;
            lat_rd_d     = rd_i;
            lat_rw_d     = RegWrite_i;
            cnt_d        = CW'(1);
            state_d      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = lat_we_q;
        dmem_addr_o  = {lat_addr_q[31:2], 2'b00};
        dmem_be_o    = lat_be_q;
        dmem_wdata_o = lat_wdata_q;
        alu_d        = lat_addr_q;
        rd_d         = lat_rd_q;
        if (dmem_ack_i) begin
          valid_d = 1'b1;
          rw_d    = lat_rw_q;
          mdata_d = lat_load_q ? load_extend(dmem_rdata_i, lat_f3_q, lat_addr_q[1:0]) : '0;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          stall_o = 1'b1;
          alu_d   = '0;
          rd_d    = '0;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_load_q  <= 1'b0;
      lat_f3_q    <= '0;
      lat_addr_q  <= '0;
      lat_be_q    <= '0;
      lat_wdata_q <= '0;
      lat_rd_q    <= '0;
      lat_rw_q    <= 1'b0;
      valid_q     <= 1'b0;
      alu_q       <= '0;
      mdata_q     <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_load_q  <= lat_load_d;
      lat_f3_q    <= lat_f3_d;
      lat_addr_q  <= lat_addr_d;
      lat_be_q    <= lat_be_d;
      lat_wdata_q <= lat_wdata_d;
      lat_rd_q    <= lat_rd_d;
      lat_rw_q    <= lat_rw_d;
      valid_q     <= valid_d;
      alu_q       <= alu_d;
      mdata_q     <= mdata_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  assign valid_o         = valid_q;
  assign ALUResult_o     = alu_q;
  assign memWrite_out2_o = mdata_q;
  assign rd_o            = rd_q;
  assign RegWrite_o      = rw_q;
  assign misalign_o      = misalign_q;
  assign timeout_o       = timeout_q;

endmodule
